// File: rtl/pipe_rg_chain.sv
// pipe_rg_chain: valid/ready register chain with bubble collapsing, hold and flush.
module pipe_rg_chain #(
   parameter int BL    = 32,
   parameter int DEPTH = 2
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       HOLD,
   input  logic                       FLUSH,
   input  logic                       IN_VALID,
   input  logic [BL-1:0]              IN_DATA,
   output logic                       IN_READY,
   output logic                       OUT_VALID,
   output logic [BL-1:0]              OUT_DATA,
   input  logic                       OUT_READY,
   output logic [$clog2(DEPTH+1)-1:0] COUNT
);
   localparam int CW = $clog2(DEPTH+1);
   logic [BL-1:0]    data_q [DEPTH];
   logic [BL-1:0]    data_d [DEPTH];
   logic [BL-1:0]    data_s [DEPTH];
   logic [DEPTH-1:0] valid_q, valid_d, valid_s, acc;
   logic [CW-1:0]    count_q, count_d;
   logic             in_xfer, out_xfer;
   // A stage can advance if it or any stage downstream of it is empty, or the sink drains.
   always_comb
      for (int k = 0; k < DEPTH; k++) acc[k] = OUT_READY | (|((~valid_q) >> k));
   assign IN_READY  = acc[0] & !HOLD & !FLUSH & !RST;
   assign OUT_VALID = valid_q[DEPTH-1] & !HOLD & !FLUSH & !RST;
   assign OUT_DATA  = data_q[DEPTH-1];
   assign COUNT     = count_q;
   assign in_xfer   = IN_VALID & IN_READY;
   assign out_xfer  = OUT_VALID & OUT_READY;
   assign valid_s   = (valid_q << 1) | DEPTH'(in_xfer);
   always_comb begin
      data_s[0] = IN_DATA;
      for (int k = 1; k < DEPTH; k++) data_s[k] = data_q[k-1];
   end
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      count_d = count_q + CW'(in_xfer) - CW'(out_xfer);
      if (FLUSH) begin
         valid_d = '0;
         count_d = '0;
      end else if (!HOLD)
         for (int k = 0; k < DEPTH; k++)
            if (acc[k]) begin
               valid_d[k] = valid_s[k];
               data_d[k]  = valid_s[k] ? data_s[k] : data_q[k];
            end
   end
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         valid_q <= '0;
         count_q <= '0;
         for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
      end else begin
         valid_q <= valid_d;
         count_q <= count_d;
         data_q  <= data_d;
      end
endmodule

// File: tb/tb_pipe_rg_chain.sv
// tb_pipe_rg_chain: directed checks of pipe_rg_chain with BL=8, DEPTH=3.
module tb_pipe_rg_chain;
   logic       CLK = 0, RST = 1, HOLD = 0, FLUSH = 0, IN_VALID = 0, OUT_READY = 0;
   logic [7:0] IN_DATA = '0, OUT_DATA;
   logic       IN_READY, OUT_VALID;
   logic [1:0] COUNT;
   int         total = 0, passed = 0, fails = 0;

   pipe_rg_chain #(.BL(8), .DEPTH(3)) dut (
      .CLK(CLK), .RST(RST), .HOLD(HOLD), .FLUSH(FLUSH),
      .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .IN_READY(IN_READY),
      .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA), .OUT_READY(OUT_READY),
      .COUNT(COUNT)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drv(input logic h, input logic f, input logic iv, input logic [7:0] d, input logic ordy);
      HOLD = h; FLUSH = f; IN_VALID = iv; IN_DATA = d; OUT_READY = ordy;
      #1;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #2;
      chk("rst_in_ready", IN_READY, 0);
      chk("rst_out_valid", OUT_VALID, 0);
      chk("rst_count", COUNT, 0);
      chk("rst_out_data", OUT_DATA, 8'h00);
      RST = 0;
      // streaming 01..04 with sink ready
      drv(0, 0, 1, 8'h01, 1);
      chk("s_in_ready", IN_READY, 1);
      tick();
      chk("s_count1", COUNT, 1);
      chk("s_ov_e0", OUT_VALID, 0);
      drv(0, 0, 1, 8'h02, 1); tick();
      chk("s_ov_e1", OUT_VALID, 0);
      drv(0, 0, 1, 8'h03, 1); tick();
      chk("s_ov_e2", OUT_VALID, 1);
      chk("s_od_01", OUT_DATA, 8'h01);
      chk("s_count3", COUNT, 3);
      drv(0, 0, 1, 8'h04, 1);
      chk("s_full_rdy", IN_READY, 1);
      tick();
      chk("s_od_02", OUT_DATA, 8'h02);
      chk("s_count_keep", COUNT, 3);
      drv(0, 0, 0, 8'h00, 1); tick();
      chk("s_od_03", OUT_DATA, 8'h03);
      tick();
      chk("s_od_04", OUT_DATA, 8'h04);
      chk("s_count_1b", COUNT, 1);
      tick();
      chk("s_empty_ov", OUT_VALID, 0);
      chk("s_empty_cnt", COUNT, 0);
      // backpressure: 5 words, sink stalled
      drv(0, 0, 1, 8'h10, 0); tick();
      drv(0, 0, 1, 8'h11, 0); tick();
      drv(0, 0, 1, 8'h12, 0); tick();
      drv(0, 0, 1, 8'h13, 0);
      chk("bp_in_ready0", IN_READY, 0);
      chk("bp_count3", COUNT, 3);
      chk("bp_od_10", OUT_DATA, 8'h10);
      tick();
      chk("bp_stall_cnt", COUNT, 3);
      chk("bp_stall_od", OUT_DATA, 8'h10);
      drv(0, 0, 1, 8'h13, 1);
      chk("bp_in_ready1", IN_READY, 1);
      tick();
      chk("bp_od_11", OUT_DATA, 8'h11);
      drv(0, 0, 1, 8'h14, 1); tick();
      chk("bp_od_12", OUT_DATA, 8'h12);
      chk("bp_cnt_keep", COUNT, 3);
      drv(0, 0, 0, 8'h00, 1); tick();
      chk("bp_od_13", OUT_DATA, 8'h13);
      tick();
      chk("bp_od_14", OUT_DATA, 8'h14);
      tick();
      chk("bp_empty", COUNT, 0);
      // hold with two words inside
      drv(0, 0, 1, 8'h20, 0); tick();
      drv(0, 0, 1, 8'h21, 0); tick();
      drv(1, 0, 1, 8'h22, 1);
      chk("h_in_ready", IN_READY, 0);
      chk("h_out_valid", OUT_VALID, 0);
      for (int i = 0; i < 4; i++) tick();
      chk("h_count", COUNT, 2);
      chk("h_out_data", OUT_DATA, 8'h14);
      drv(0, 0, 0, 8'h00, 1); tick();
      chk("h_od_20", OUT_DATA, 8'h20);
      chk("h_ov", OUT_VALID, 1);
      tick();
      chk("h_od_21", OUT_DATA, 8'h21);
      chk("h_cnt1", COUNT, 1);
      tick();
      chk("h_empty", COUNT, 0);
      // flush while full, held, and offered a word
      drv(0, 0, 1, 8'h30, 0); tick();
      drv(0, 0, 1, 8'h31, 0); tick();
      drv(0, 0, 1, 8'h32, 0); tick();
      chk("f_full", COUNT, 3);
      drv(1, 1, 1, 8'h33, 1);
      chk("f_in_ready", IN_READY, 0);
      chk("f_out_valid", OUT_VALID, 0);
      tick();
      drv(0, 0, 0, 8'h00, 1);
      chk("f_count0", COUNT, 0);
      chk("f_ov0", OUT_VALID, 0);
      chk("f_data_kept", OUT_DATA, 8'h30);
      drv(0, 0, 1, 8'h40, 1); tick();
      drv(0, 0, 0, 8'h00, 1); tick();
      tick();
      chk("f_post_od", OUT_DATA, 8'h40);
      chk("f_post_cnt", COUNT, 1);
      tick();
      // bubble collapse
      drv(0, 0, 1, 8'hA5, 0); tick();
      drv(0, 0, 0, 8'h00, 0); tick();
      drv(0, 0, 1, 8'h5A, 0); tick();
      drv(0, 0, 0, 8'h00, 0); tick();
      chk("b_count2", COUNT, 2);
      chk("b_od_a5", OUT_DATA, 8'hA5);
      chk("b_in_ready", IN_READY, 1);
      // asynchronous reset between edges with two words in flight
      #2;
      RST = 1;
      #1;
      chk("ar_count", COUNT, 0);
      chk("ar_ov", OUT_VALID, 0);
      chk("ar_od", OUT_DATA, 8'h00);
      chk("ar_in_ready", IN_READY, 0);
      #1;
      RST = 0;
      drv(0, 0, 1, 8'h50, 1);
      chk("ar_rdy_after", IN_READY, 1);
      tick();
      chk("ar_first_xfer", COUNT, 1);
      drv(0, 0, 0, 8'h00, 1); tick();
      tick();
      chk("ar_od_50", OUT_DATA, 8'h50);
      chk("ar_cnt_final", COUNT, 1);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/pipe_rg_chain.md
PIPE_RG_CHAIN -- requirements
Module: pipe_rg_chain

Interface
REQ-001 SHALL have parameter BL, default 32, data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 2, number of register stages (>=1).
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port HOLD  input  1  stall; 1 freezes all stages.
REQ-006 SHALL have port FLUSH  input  1  clear; 1 invalidates all stages at next edge.
REQ-007 SHALL have port IN_VALID  input  1  upstream word present.
REQ-008 SHALL have port IN_DATA  input  BL  upstream word.
REQ-009 SHALL have port IN_READY  output  1  chain accepts IN_DATA this cycle.
REQ-010 SHALL have port OUT_VALID  output  1  stage DEPTH-1 presents a word.
REQ-011 SHALL have port OUT_DATA  output  BL  data of stage DEPTH-1.
REQ-012 SHALL have port OUT_READY  input  1  downstream accepts OUT_DATA.
REQ-013 SHALL have port COUNT  output  $clog2(DEPTH+1)  number of valid stages (registered).

Function
REQ-014 SHALL hold per stage k (0..DEPTH-1) a BL-bit data register D[k] and a valid bit V[k]; stage 0 is input side, stage DEPTH-1 drives OUT_DATA/OUT_VALID.
REQ-015 SHALL define combinationally: acc[DEPTH-1] = !V[DEPTH-1] | OUT_READY; acc[k] = !V[k] | acc[k+1] for k<DEPTH-1 (bubble collapsing).
REQ-016 SHALL drive IN_READY = acc[0] & !HOLD & !FLUSH.
REQ-017 SHALL drive OUT_VALID = V[DEPTH-1] & !HOLD & !FLUSH; OUT_DATA = D[DEPTH-1] at all times.
REQ-018 Input transfer SHALL occur when IN_VALID & IN_READY; output transfer when OUT_VALID & OUT_READY.
REQ-019 With HOLD=0, FLUSH=0, at each edge each stage k with acc[k]=1 SHALL load D[k]/V[k] from stage k-1 (stage 0 from IN_DATA/IN_VALID&IN_READY); stages with acc[k]=0 SHALL keep state.
REQ-020 D[k] SHALL only be written when the incoming valid is 1; a bubble moving in sets V[k]=0 and leaves D[k] unchanged.
REQ-021 HOLD=1, FLUSH=0 SHALL leave all D, V, COUNT unchanged; no transfers occur.
REQ-022 FLUSH=1 SHALL clear all V at next edge and set COUNT=0, regardless of HOLD, IN_VALID, OUT_READY; D unchanged.
REQ-023 Latency into an empty, unstalled chain with OUT_READY=1 SHALL be DEPTH cycles from input transfer edge to OUT_VALID=1.
REQ-024 Sustained throughput SHALL be one word per cycle when IN_VALID=1, OUT_READY=1, HOLD=0.
REQ-025 When full (COUNT=DEPTH) and OUT_READY=0, IN_READY SHALL be 0; when full and OUT_READY=1, IN_READY SHALL be 1 (simultaneous in/out, COUNT unchanged).
REQ-026 COUNT next value SHALL be COUNT + in_xfer - out_xfer, never exceeding DEPTH nor below 0.
REQ-027 Word order SHALL be preserved; no word duplicated or dropped except by FLUSH.

Reset
REQ-028 RST=1 SHALL asynchronously clear all V to 0, all D to 0, COUNT to 0, without waiting for CLK.
REQ-029 While RST=1, IN_READY and OUT_VALID SHALL be 0; RST asserted mid-transfer SHALL discard all in-flight words.
REQ-030 After RST deasserts, first input transfer SHALL be possible at the first CLK edge.

Verification (BL=8, DEPTH=3)
REQ-031 Stream 0x01,0x02,0x03,0x04 on consecutive cycles, OUT_READY=1 -> OUT_VALID rises 3 cycles after first accept; outputs 0x01..0x04 back-to-back; COUNT peaks 3.
REQ-032 OUT_READY=0, push 5 words -> IN_READY falls after 3 accepts, COUNT=3, OUT_DATA=first word; OUT_READY=1 -> words drain in order, IN_READY=1 same cycle.
REQ-033 Chain with 2 words, assert HOLD 4 cycles with IN_VALID=1, OUT_READY=1 -> IN_READY=0, OUT_VALID=0, COUNT and D unchanged; release -> resumes in order.
REQ-034 Chain full, FLUSH=1 with HOLD=1 and IN_VALID=1 -> next cycle COUNT=0, OUT_VALID=0, input word not taken.
REQ-035 Single word 0xA5 inserted, gap, then 0x5A with OUT_READY=0 -> bubble collapses: 0xA5 in stage 2, 0x5A in stage 1, COUNT=2.
REQ-036 Assert RST between clock edges with COUNT=2 -> COUNT=0, OUT_VALID=0, OUT_DATA=0x00 immediately, before next edge.
